count_arb: RTL and testbench
============================

COUNT_ARB -- requirements
Module: count_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port req, input, 2 bits: req[i] high means requester i wants an interval.
REQ-004 SHALL have port dur0, input, 4 bits: interval length in cycles for requester 0.
REQ-005 SHALL have port dur1, input, 4 bits: interval length in cycles for requester 1.
REQ-006 SHALL have port gnt, output, 2 bits: one-hot owner of the shared counter; all-zero when free.
REQ-007 SHALL have port count_en, output, 1 bit: high in every cycle the shared counter increments.
REQ-008 SHALL have port q, output, 4 bits: shared counter value.
REQ-009 SHALL have port done, output, 2 bits: one-cycle pulse marking completion for requester i.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, GRANT, RUN and DONE.
REQ-012 IDLE: if any req bit is high, SHALL select a winner (REQ-020), set gnt, and enter GRANT on the next edge.
REQ-013 GRANT: one cycle; SHALL clear q to 0 and latch the winner's duration into dur_l; count_en low.
REQ-014 GRANT with dur_l = 0 SHALL go directly to DONE; otherwise SHALL go to RUN.
REQ-015 RUN: count_en high; q SHALL increment by 1 each cycle; when q+1 == dur_l, SHALL enter DONE. RUN therefore lasts exactly dur_l cycles and q ends at dur_l.
REQ-016 DONE: one cycle; done[owner] SHALL be high and count_en low; the next state SHALL be IDLE, with q holding its value.
REQ-017 gnt SHALL stay stable and one-hot through GRANT, RUN and DONE, and SHALL be zero in IDLE.
REQ-018 If the owner's req drops during GRANT or RUN, the block SHALL abort to IDLE on the next edge: no done pulse, count_en low from that edge, q holds.
REQ-019 Changes to dur0/dur1 after GRANT SHALL have no effect on the current interval.
REQ-020 If only one req bit is high, that requester SHALL win; simultaneous requests SHALL be resolved per REQ-025/026.
REQ-021 A request held high through DONE SHALL be re-arbitrated in the following IDLE cycle. Minimum turnaround from DONE to next GRANT is 2 cycles.
REQ-022 q SHALL never exceed 15; there is no wrap-around inside an interval (dur_l ≤ 15).

Reset
REQ-023 On clr high, the block SHALL immediately and asynchronously set: state IDLE, gnt=00, count_en=0, q=0000, done=00, busy=0, dur_l=0, round-robin pointer pointing to requester 0.
REQ-024 clr asserted mid-RUN SHALL discard the interval with no done pulse; after clr falls, operation SHALL restart from IDLE.

Configuration
REQ-025 With macro COUNT_ARB_RR_EN defined, simultaneous requests SHALL be arbitrated round-robin: the winner is the requester not served last, and the pointer updates on DONE or abort.
REQ-026 Without COUNT_ARB_RR_EN, requester 0 SHALL always win simultaneous requests (fixed priority) and no pointer register SHALL exist.

Verification
REQ-027 clr=1 for 50 ns, then release with req=00 -> gnt=00, q=0, count_en=0, busy=0 throughout.
REQ-028 req=01, dur0=5 -> GRANT 1 cycle, count_en high 5 cycles with q counting 1..5, done=01 for 1 cycle, then IDLE with q=5.
REQ-029 req=11, dur0=3, dur1=4, held high, with RR_EN -> grant order 0,1,0,1; without RR_EN -> 0,0,0.
REQ-030 req=10, dur1=0 -> GRANT then DONE immediately, count_en never high, done=10, q=0.
REQ-031 req=01, dur0=10; drop req0 when q=4 -> IDLE next edge, no done pulse, q holds 4 (or 5 if the drop lands after the increment edge).
REQ-032 clr pulsed when q=6 in RUN -> all outputs zero immediately, no done pulse; then req=10, dur1=2 completes normally.

Source files
------------

// File: rtl/count_arb_if.sv
// Bundle of request, duration, grant and counter signals shared by count_arb and its requester side.
interface count_arb_if;
  logic [1:0] req;
  logic [3:0] dur0;
  logic [3:0] dur1;
  logic [1:0] gnt;
  logic       count_en;
  logic [3:0] q;
  logic [1:0] done;
  logic       busy;

  modport master (output req, dur0, dur1, input gnt, count_en, q, done, busy);
  modport slave  (input req, dur0, dur1, output gnt, count_en, q, done, busy);
endinterface

// File: rtl/count_arb.sv
// Two-requester arbiter that lends one 4-bit counter for a requested number of cycles.
// Define COUNT_ARB_RR_EN for round-robin on simultaneous requests; otherwise requester 0 wins.
module count_arb (
  input  logic        clk,
  input  logic        clr,
  count_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] dur_l_q, dur_l_d;
  logic [1:0] win;
  logic       own_req;
  logic [3:0] own_dur;
  logic [3:0] cnt_inc;
  logic       count_en_w;

  assign own_req = |(bus.req & gnt_q);
  assign own_dur = gnt_q[1] ? bus.dur1 : bus.dur0;
  assign cnt_inc = cnt_q + 4'd1;

`ifdef COUNT_ARB_RR_EN
  // ptr_q names the requester preferred on a tie; it moves away from whoever was just served.
  logic ptr_q, ptr_d;
  logic abort;

  assign abort = ((state_q == GRANT) || (state_q == RUN)) && !own_req;
  assign ptr_d = ((state_q == DONE) || abort) ? gnt_q[0] : ptr_q;
  assign win   = (bus.req == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : bus.req;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  assign win = bus.req[0] ? 2'b01 : (bus.req[1] ? 2'b10 : 2'b00);
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    dur_l_d    = dur_l_q;
    count_en_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_req) begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end else begin
          cnt_d   = 4'd0;
          dur_l_d = own_dur;
          state_d = (own_dur == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Losing the owner's request aborts before this edge's increment, so q holds.
        if (!own_req) begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end else begin
          count_en_w = 1'b1;
          cnt_d      = cnt_inc;
          if (cnt_inc == dur_l_q) state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= 4'd0;
      dur_l_q <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      dur_l_q <= dur_l_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.count_en = count_en_w;
  assign bus.q        = cnt_q;
  assign bus.done     = (state_q == DONE) ? gnt_q : 2'b00;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_count_arb.sv
// Randomized scoreboard bench for count_arb: the driver predicts each interval's owner and length,
// a monitor checks every done pulse against those predictions.
module tb_count_arb;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  count_arb_if bus ();
  count_arb dut (.clk(clk), .clr(clr), .bus(bus));

  typedef struct { int owner; int dur; } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ptr     = 0;  // requester the reference model favours on a tie

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef COUNT_ARB_RR_EN
    return ptr;
`else
    return 0;
`endif
  endfunction

  // Monitor: counts count_en cycles of each interval and checks every done pulse.
  logic [1:0] prev_gnt = 2'b00;
  int en_cnt = 0;
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (clr) begin
      en_cnt   = 0;
      prev_gnt = 2'b00;
    end else begin
      if (bus.gnt != 2'b00 && prev_gnt == 2'b00) en_cnt = 0;
      if (bus.count_en) en_cnt++;
      if (bus.done != 2'b00) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=%0d q=%0d, expected no pulse", bus.done, bus.q);
        end else begin
          e = sb.pop_front();
          chk("done_onehot", bus.done, 32'(1 << e.owner));
          chk("q_at_done", bus.q, e.dur);
          chk("count_en_cycles", en_cnt, e.dur);
          chk("gnt_at_done", bus.gnt, 32'(1 << e.owner));
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  // Issue one request set from a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
  task automatic txn(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1);
    int w;
    bit seen;
    w    = pick(r);
    seen = 1'b0;
    sb.push_back('{w, (w == 1) ? int'(d1) : int'(d0)});
    bus.req  = r;
    bus.dur0 = d0;
    bus.dur1 = d1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) seen = 1'b1;
      else if (i >= 2) begin
        bus.dur0 = 4'($urandom_range(0, 15));
        bus.dur1 = 4'($urandom_range(0, 15));
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_timeout: got no done in 40 cycles, expected done for requester %0d", w);
    end else begin
      ptr = 1 - w;
    end
  endtask

  task automatic wait_q(input logic [3:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (bus.busy && bus.q == v) hit = 1'b1;
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_q_timeout: got q=%0d, expected q=%0d", bus.q, v);
    end
  endtask

  initial begin
    clr      = 1'b1;
    bus.req  = 2'b00;
    bus.dur0 = 4'd0;
    bus.dur1 = 4'd0;
    #23;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_q", bus.q, 0);
    chk("rst_count_en", bus.count_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    #27;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_gnt", bus.gnt, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_q", bus.q, 0);
      chk("idle_count_en", bus.count_en, 0);
    end

    // Basic interval, then q must hold its final value in IDLE.
    txn(2'b01, 4'd5, 4'd0);
    bus.req = 2'b00;
    @(negedge clk);
    chk("hold_q_after_done", bus.q, 5);
    chk("hold_busy", bus.busy, 0);

    // Zero-length interval.
    txn(2'b10, 4'd9, 4'd0);
    bus.req = 2'b00;
    @(negedge clk);
    chk("zero_dur_q", bus.q, 0);

    // Both requesting and held through DONE.
    for (int i = 0; i < 4; i++) txn(2'b11, 4'd3, 4'd4);
    bus.req = 2'b00;
    @(negedge clk);

    // Owner drops its request mid-run.
    bus.req  = 2'b01;
    bus.dur0 = 4'd10;
    wait_q(4'd4);
    bus.req = 2'b00;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_gnt", bus.gnt, 0);
    chk("abort_q", bus.q, 4);
    chk("abort_count_en", bus.count_en, 0);
    repeat (2) @(negedge clk);
    chk("abort_q_hold", bus.q, 4);
    ptr = 1;

    // Reset pulse mid-run.
    bus.req  = 2'b01;
    bus.dur0 = 4'd12;
    wait_q(4'd6);
    clr = 1'b1;
    #1;
    chk("clr_gnt", bus.gnt, 0);
    chk("clr_q", bus.q, 0);
    chk("clr_count_en", bus.count_en, 0);
    chk("clr_done", bus.done, 0);
    chk("clr_busy", bus.busy, 0);
    bus.req = 2'b00;
    ptr = 0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    txn(2'b10, 4'd0, 4'd2);

    for (int n = 0; n < 60; n++) begin
      txn(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        bus.req = 2'b00;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
